// File: rtl/param_data_memory.sv
// rtl/param_data_memory.sv - byte-addressed little-endian data memory with fixed access latency
module param_data_memory #(
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [63:0]           Write_Data,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic                  Ready,
    output logic                  Done,
    output logic [63:0]           Read_Data,
    output logic                  Mem_Error
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [3:0]       count;
    logic [IDX_W-1:0] cap_idx;
    logic [1:0]       cap_size;
    logic             cap_unsigned;
    logic             cap_read;
    logic             cap_err;

    logic [7:0]       mem [DEPTH] = '{default: 8'h00};

    logic [IDX_W-1:0] idx;
    logic [7:0]       wr_en;
    logic [2:0]       align_mask;
    logic             req_err;
    logic             do_store;
    logic [63:0]      raw;
    logic [63:0]      load_val;
    logic             unused_addr;

    // Upper address bits are don't-care: the array wraps modulo DEPTH.
    assign idx         = Mem_Addr[IDX_W-1:0];
    assign unused_addr = ^Mem_Addr;
    assign Ready       = (state == IDLE);

    always_comb begin
        wr_en      = 8'h01;
        align_mask = 3'b000;
        case (Size)
            2'd0: begin wr_en = 8'h01; align_mask = 3'b000; end
            2'd1: begin wr_en = 8'h03; align_mask = 3'b001; end
            2'd2: begin wr_en = 8'h0F; align_mask = 3'b011; end
            default: begin wr_en = 8'hFF; align_mask = 3'b111; end
        endcase
    end

    assign req_err  = ((idx[2:0] & align_mask) != 3'b000) || (MemRead && MemWrite);
    assign do_store = !reset && Ready && MemWrite && !req_err;

    // Stores commit on the acceptance edge; reset never touches the array.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i]) begin
                    mem[idx + IDX_W'(i)] <= Write_Data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem[cap_idx + IDX_W'(i)];
        end
        case (cap_size)
            2'd0:    load_val = cap_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    load_val = cap_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    load_val = cap_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_val = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            Done         <= 1'b0;
            Mem_Error    <= 1'b0;
            Read_Data    <= 64'd0;
            cap_idx      <= '0;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_read     <= 1'b0;
            cap_err      <= 1'b0;
        end else begin
            Done      <= 1'b0;
            Mem_Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        state        <= BUSY;
                        count        <= 4'(LATENCY - 1);
                        cap_idx      <= idx;
                        cap_size     <= Size;
                        cap_unsigned <= Unsigned;
                        cap_read     <= MemRead;
                        cap_err      <= req_err;
                    end
                end
                default: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state     <= IDLE;
                        Done      <= 1'b1;
                        Mem_Error <= cap_err;
                        if (cap_read && !cap_err) begin
                            Read_Data <= load_val;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_data_memory.sv
// tb/tb_param_data_memory.sv - directed table-driven bench for param_data_memory
module tb_param_data_memory;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Mem_Addr, Write_Data;
    logic        MemWrite, MemRead, Unsigned;
    logic [1:0]  Size;
    logic        Ready, Done, Mem_Error;
    logic [63:0] Read_Data;

    logic [63:0] addr1;
    logic        rd1;
    logic        Ready1, Done1, Mem_Error1;
    logic [63:0] Read_Data1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    param_data_memory #(.DEPTH(256), .LATENCY(2), .ADDR_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
        .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
        .Ready(Ready), .Done(Done), .Read_Data(Read_Data), .Mem_Error(Mem_Error)
    );

    param_data_memory #(.DEPTH(256), .LATENCY(1), .ADDR_WIDTH(64)) dut1 (
        .clk(clk), .reset(reset), .Mem_Addr(addr1), .Write_Data(64'd0),
        .MemWrite(1'b0), .MemRead(rd1), .Size(2'd3), .Unsigned(1'b0),
        .Ready(Ready1), .Done(Done1), .Read_Data(Read_Data1), .Mem_Error(Mem_Error1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        err;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[$];

    int          got_lat;
    logic        got_err;
    logic [63:0] got_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access: present request, accept, then wait (bounded) for Done.
    task automatic access(input vec_t v);
        @(negedge clk);
        chk("ready_before_access", {63'd0, Ready}, 64'd1);
        MemRead    = v.rd;
        MemWrite   = v.wr;
        Mem_Addr   = v.addr;
        Write_Data = v.wdata;
        Size       = v.size;
        Unsigned   = v.uns;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        got_lat  = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (Done) begin
                got_lat   = n;
                got_err   = Mem_Error;
                got_rdata = Read_Data;
                break;
            end
            chk("err_without_done", {63'd0, Mem_Error}, 64'd0);
        end
    endtask

    initial begin
        int dcount;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Mem_Addr = '0;
        Write_Data = '0; Size = 2'd0; Unsigned = 1'b0; rd1 = 1'b0; addr1 = '0;

        //            rd    wr    addr                    wdata                   sz    uns   err   rdata
        vecs.push_back('{1'b0, 1'b1, 64'h8,               64'h1122334455667788, 2'd3, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 64'h8,               64'h0,                2'd3, 1'b0, 1'b0, 64'h1122334455667788});
        vecs.push_back('{1'b1, 1'b0, 64'h8,               64'h0,                2'd0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFF88});
        vecs.push_back('{1'b1, 1'b0, 64'h8,               64'h0,                2'd0, 1'b1, 1'b0, 64'h0000000000000088});
        vecs.push_back('{1'b1, 1'b0, 64'hA,               64'h0,                2'd1, 1'b0, 1'b0, 64'h0000000000005566});
        vecs.push_back('{1'b0, 1'b1, 64'h6,               64'hDEADBEEFCAFEF00D, 2'd2, 1'b0, 1'b1, 64'h0000000000005566});
        vecs.push_back('{1'b1, 1'b0, 64'h6,               64'h0,                2'd1, 1'b1, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 64'h8,               64'h0,                2'd3, 1'b0, 1'b0, 64'h1122334455667788});
        vecs.push_back('{1'b1, 1'b1, 64'h0,               64'hFFFFFFFFFFFFFFFF, 2'd3, 1'b0, 1'b1, 64'h1122334455667788});
        vecs.push_back('{1'b1, 1'b0, 64'h0,               64'h0,                2'd3, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 1'b1, 64'h100,             64'h00000000000000AB, 2'd0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 64'h0,               64'h0,                2'd0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFAB});
        vecs.push_back('{1'b1, 1'b0, 64'h9,               64'h0,                2'd1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFAB});
        vecs.push_back('{1'b0, 1'b1, 64'h20,              64'h0000000000008001, 2'd1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFAB});
        vecs.push_back('{1'b1, 1'b0, 64'h20,              64'h0,                2'd1, 1'b0, 1'b0, 64'hFFFFFFFFFFFF8001});
        vecs.push_back('{1'b1, 1'b0, 64'h20,              64'h0,                2'd2, 1'b0, 1'b0, 64'h0000000000008001});
        vecs.push_back('{1'b0, 1'b1, 64'h24,              64'h1234567887654321, 2'd2, 1'b0, 1'b0, 64'h0000000000008001});
        vecs.push_back('{1'b1, 1'b0, 64'h24,              64'h0,                2'd2, 1'b0, 1'b0, 64'hFFFFFFFF87654321});
        vecs.push_back('{1'b1, 1'b0, 64'h24,              64'h0,                2'd2, 1'b1, 1'b0, 64'h0000000087654321});
        vecs.push_back('{1'b1, 1'b0, 64'h20,              64'h0,                2'd3, 1'b1, 1'b0, 64'h8765432100008001});
        vecs.push_back('{1'b0, 1'b1, 64'hFFFF000000000010, 64'h000000000000005A, 2'd0, 1'b0, 1'b0, 64'h8765432100008001});
        vecs.push_back('{1'b1, 1'b0, 64'h10,              64'h0,                2'd0, 1'b1, 1'b0, 64'h000000000000005A});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready",     {63'd0, Ready},     64'd1);
        chk("reset_done",      {63'd0, Done},      64'd0);
        chk("reset_mem_error", {63'd0, Mem_Error}, 64'd0);
        chk("reset_read_data", Read_Data,          64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i]);
            chk($sformatf("v%0d_latency", i), 64'(got_lat), 64'd3);
            chk($sformatf("v%0d_error", i), {63'd0, got_err}, {63'd0, vecs[i].err});
            chk($sformatf("v%0d_read_data", i), got_rdata, vecs[i].rdata);
        end

        // Reset one cycle after accepting a load aborts it silently.
        @(negedge clk);
        MemRead = 1'b1; Mem_Addr = 64'h8; Size = 2'd3; Unsigned = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, Ready}, 64'd0);
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready",     {63'd0, Ready}, 64'd1);
        chk("abort_read_data", Read_Data,      64'd0);
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (Done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);

        // Request held through the whole busy period is serviced once.
        MemRead = 1'b1; Mem_Addr = 64'h8; Size = 2'd3;
        dcount = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (Done) dcount++;
            if (k == 3) MemRead = 1'b0;
        end
        chk("held_single_done", 64'(dcount), 64'd1);
        chk("held_read_data",   Read_Data,   64'h1122334455667788);

        // LATENCY=1 continuous loads: one completion every second cycle.
        @(negedge clk);
        chk("lat1_idle", {63'd0, Ready1}, 64'd1);
        rd1 = 1'b1; addr1 = 64'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("lat1_ready_%0d", k), {63'd0, Ready1}, {63'd0, (k % 2 == 0)});
            chk($sformatf("lat1_done_%0d", k),  {63'd0, Done1},  {63'd0, (k % 2 == 0)});
            chk($sformatf("lat1_err_%0d", k),   {63'd0, Mem_Error1}, 64'd0);
        end
        rd1 = 1'b0;
        chk("lat1_read_data", Read_Data1, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DEPTH, default 256: memory size in bytes; power of two, minimum 8.
REQ-002 Parameter LATENCY, default 2: cycles from accept to completion; legal range 1..15.
REQ-003 Parameter ADDR_WIDTH, default 64: width of Mem_Addr.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Mem_Addr  input  ADDR_WIDTH  byte address of the access.
REQ-007 Write_Data  input  64  store data; the low Size-bytes are used.
REQ-008 MemWrite  input  1  store request.
REQ-009 MemRead  input  1  load request.
REQ-010 Size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-011 Unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend; ignored when Size=11.
REQ-012 Ready  output  1  block idle, request accepted this edge.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 Read_Data  output  64  registered load result.
REQ-015 Mem_Error  output  1  qualifies Done; the completed access was rejected.

Function
REQ-016 Storage SHALL be a DEPTH-entry byte array, little-endian; only Mem_Addr[log2(DEPTH)-1:0] is used, upper bits ignored (address wraps modulo DEPTH).
REQ-017 FSM SHALL have states IDLE and BUSY; Ready=1 exactly when state is IDLE.
REQ-018 Request accepted at edge E0 when state=IDLE and MemRead|MemWrite=1; state->BUSY, counter<=LATENCY-1, Size/Unsigned/address/op captured.
REQ-019 Request inputs sampled while BUSY SHALL be ignored; no queuing.
REQ-020 Legal store SHALL write the Size-bytes of Write_Data into the array at edge E0.
REQ-021 In BUSY, counter SHALL decrement each edge while nonzero; at the edge where counter=0 (E0+LATENCY), state->IDLE and Done=1 for the following cycle only.
REQ-022 Legal load SHALL update Read_Data at the completion edge with the Size-bytes at the captured address, extended to 64 bits per Unsigned.
REQ-023 Read_Data SHALL hold its value after completion and on every store or errored access.
REQ-024 Access is misaligned when the address is not a multiple of 2^Size bytes; misaligned access SHALL not modify the array and SHALL complete after the normal latency with Done=1, Mem_Error=1.
REQ-025 MemRead=1 and MemWrite=1 together at acceptance SHALL be treated as an errored access: no array update, Done=1, Mem_Error=1 at completion.
REQ-026 Mem_Error SHALL be 0 whenever Done=0.
REQ-027 A new request SHALL be acceptable at the edge ending the Done cycle (back-to-back throughput: one access per LATENCY+1 cycles).
REQ-028 A load that follows a store to the same bytes SHALL return the stored data.

Reset
REQ-029 reset=1 at an edge SHALL set state=IDLE, counter=0, Ready=1, Done=0, Mem_Error=0, Read_Data=0.
REQ-030 reset SHALL take priority over any request at the same edge; that request is not accepted.
REQ-031 reset during BUSY SHALL abort the transaction with no Done pulse; a store already committed at acceptance remains in the array.
REQ-032 Array contents SHALL NOT be altered by reset; array is zero at time 0 (simulation initialisation).

Verification
REQ-033 LATENCY=2: store Size=11 addr 8 data 64'h1122334455667788, then load Size=11 addr 8 -> Done 3 cycles after each acceptance edge, Read_Data=64'h1122334455667788, Mem_Error=0.
REQ-034 After REQ-033 data, load Size=00 addr 8 Unsigned=0 -> Read_Data=64'hFFFFFFFFFFFFFF88; Unsigned=1 -> 64'h0000000000000088; Size=01 addr 10 Unsigned=0 -> 64'h0000000000005566.
REQ-035 Store Size=10 addr 6 -> Done with Mem_Error=1, bytes 6..9 unchanged; MemRead=MemWrite=1 addr 0 -> Mem_Error=1, Read_Data unchanged.
REQ-036 DEPTH=256: store byte 8'hAB at addr 64'h100 -> load Size=00 addr 0 returns 64'hFFFFFFFFFFFFFFAB (wrap-around).
REQ-037 Assert reset one cycle after accepting a load -> no Done pulse, Ready=1 next cycle, Read_Data=0; request held during BUSY is not accepted (single Done observed).
REQ-038 LATENCY=1 back-to-back loads held continuously -> Done every 2nd cycle, Ready toggles 1/0 each cycle.
